// File: rtl/baccarat_statemachine.sv
// baccarat_statemachine
//   Moore controller that sequences the card datapath through one punto-banco
//   hand. It strobes the six card registers in deal order P1,D1,P2,D2[,P3][,D3],
//   reads back the hand scores and the player's third card to apply the tableau
//   rules, and lights the winner once the hand is over.
//
// Ports
//   slow_clock        in  1        game clock shared with the datapath card registers
//   reset             in  1        synchronous, active-high; returns to S_IDLE
//   pscore_in         in  SCORE_W  player hand score (0..9) from the datapath
//   dscore_in         in  SCORE_W  dealer hand score (0..9) from the datapath
//   pcard3_in         in  CARD_W   player third card code (0=empty, 1=A..13=K)
//   load_pcard1..3    out 1 each   one-cycle load strobes, player card registers
//   load_dcard1..3    out 1 each   one-cycle load strobes, dealer card registers
//   player_win_light  out 1        player wins or tie (only in S_DONE)
//   dealer_win_light  out 1        dealer wins or tie (only in S_DONE)
//   done              out 1        hand finished; held until reset
//   state_dbg         out 4        current FSM state encoding, for observation
//
// Handshake: there is no valid/ready pairing here. Each load_* is a strobe that
// is high for exactly one slow_clock cycle; the datapath captures on the edge
// that ends that cycle. Scores are only meaningful one cycle after the matching
// load, which is why the evaluation states sit after the loads.
module baccarat_statemachine #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] pscore_in,
  input  logic [SCORE_W-1:0] dscore_in,
  input  logic [CARD_W-1:0]  pcard3_in,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light,
  output logic               done,
  output logic [3:0]         state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_P1    = 4'd1,
    S_D1    = 4'd2,
    S_P2    = 4'd3,
    S_D2    = 4'd4,
    S_EVAL1 = 4'd5,
    S_P3    = 4'd6,
    S_EVAL2 = 4'd7,
    S_D3    = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  localparam logic [SCORE_W-1:0] SC_2 = SCORE_W'(2);
  localparam logic [SCORE_W-1:0] SC_3 = SCORE_W'(3);
  localparam logic [SCORE_W-1:0] SC_4 = SCORE_W'(4);
  localparam logic [SCORE_W-1:0] SC_5 = SCORE_W'(5);
  localparam logic [SCORE_W-1:0] SC_6 = SCORE_W'(6);
  localparam logic [SCORE_W-1:0] SC_8 = SCORE_W'(8);

  localparam logic [CARD_W-1:0] CV_0 = CARD_W'(0);
  localparam logic [CARD_W-1:0] CV_1 = CARD_W'(1);
  localparam logic [CARD_W-1:0] CV_2 = CARD_W'(2);
  localparam logic [CARD_W-1:0] CV_4 = CARD_W'(4);
  localparam logic [CARD_W-1:0] CV_6 = CARD_W'(6);
  localparam logic [CARD_W-1:0] CV_7 = CARD_W'(7);
  localparam logic [CARD_W-1:0] CV_8 = CARD_W'(8);
  localparam logic [CARD_W-1:0] CV_9 = CARD_W'(9);

  state_t state, next_state;

  // Baccarat value of the player's third card: tens, face cards and the empty
  // code all count as zero.
  logic [CARD_W-1:0] p3_value;
  assign p3_value = (pcard3_in >= CV_1 && pcard3_in <= CV_9) ? pcard3_in : CV_0;

  // Banker tableau once the player has drawn a third card.
  logic dealer_draws_after_p3;
  always_comb begin
    dealer_draws_after_p3 = 1'b0;
    if (dscore_in <= SC_2)
      dealer_draws_after_p3 = 1'b1;
    else if (dscore_in == SC_3)
      dealer_draws_after_p3 = (p3_value != CV_8);
    else if (dscore_in == SC_4)
      dealer_draws_after_p3 = (p3_value >= CV_2) && (p3_value <= CV_7);
    else if (dscore_in == SC_5)
      dealer_draws_after_p3 = (p3_value >= CV_4) && (p3_value <= CV_7);
    else if (dscore_in == SC_6)
      dealer_draws_after_p3 = (p3_value >= CV_6) && (p3_value <= CV_7);
    else
      dealer_draws_after_p3 = 1'b0;
  end

  // State register
  always_ff @(posedge slow_clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  next_state = S_P1;
      S_P1:    next_state = S_D1;
      S_D1:    next_state = S_P2;
      S_P2:    next_state = S_D2;
      S_D2:    next_state = S_EVAL1;
      S_EVAL1: begin
        if (pscore_in >= SC_8 || dscore_in >= SC_8)
          next_state = S_DONE;             // natural: nobody draws
        else if (pscore_in <= SC_5)
          next_state = S_P3;
        else if (dscore_in <= SC_5)
          next_state = S_D3;               // player stands on 6/7
        else
          next_state = S_DONE;
      end
      S_P3:    next_state = S_EVAL2;
      S_EVAL2: next_state = dealer_draws_after_p3 ? S_D3 : S_DONE;
      S_D3:    next_state = S_DONE;
      S_DONE:  next_state = S_DONE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode. Lights depend on state plus the live scores, which the
  // datapath holds stable once the hand is over.
  always_comb begin
    load_pcard1      = (state == S_P1);
    load_dcard1      = (state == S_D1);
    load_pcard2      = (state == S_P2);
    load_dcard2      = (state == S_D2);
    load_pcard3      = (state == S_P3);
    load_dcard3      = (state == S_D3);
    done             = (state == S_DONE);
    player_win_light = (state == S_DONE) && (pscore_in >= dscore_in);
    dealer_win_light = (state == S_DONE) && (dscore_in >= pscore_in);
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_baccarat_statemachine.sv
module tb_baccarat_statemachine;

  logic       slow_clock = 1'b0;
  logic       reset      = 1'b1;
  logic [3:0] pscore_in  = 4'd0;
  logic [3:0] dscore_in  = 4'd0;
  logic [3:0] pcard3_in  = 4'd0;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic       player_win_light, dealer_win_light, done;
  logic [3:0] state_dbg;

  baccarat_statemachine #(.CARD_W(4), .SCORE_W(4)) dut (
    .slow_clock       (slow_clock),
    .reset            (reset),
    .pscore_in        (pscore_in),
    .dscore_in        (dscore_in),
    .pcard3_in        (pcard3_in),
    .load_pcard1      (load_pcard1),
    .load_pcard2      (load_pcard2),
    .load_pcard3      (load_pcard3),
    .load_dcard1      (load_dcard1),
    .load_dcard2      (load_dcard2),
    .load_dcard3      (load_dcard3),
    .player_win_light (player_win_light),
    .dealer_win_light (dealer_win_light),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 slow_clock = ~slow_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Event codes: 1=P1 2=D1 3=P2 4=D2 5=P3 6=D3, 8+{pwin,dwin}=done with lights.
  logic [3:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
    end
  endtask

  task automatic compare_event(input logic [3:0] got);
    logic [3:0] req;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got code %0d, required none (t=%0t)", got, $time);
    end else begin
      req = exp_q.pop_front();
      if (got !== req) begin
        n_fail++;
        $display("FAIL event_order: got code %0d, required %0d (t=%0t)", got, req, $time);
      end
    end
  endtask

  // ---------------- monitor ----------------
  logic [5:0] mon_loads;
  logic [3:0] mon_code;
  logic       done_q = 1'b0;

  always @(negedge slow_clock) begin
    mon_loads = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    if (mon_loads != 6'd0) begin
      check("load_onehot", 32'($onehot(mon_loads)), 32'd1);
      mon_code = 4'd0;
      for (int i = 5; i >= 0; i--)
        if (mon_loads[i]) mon_code = 4'(i + 1);
      compare_event(mon_code);
    end
    if (done && !done_q)
      compare_event({2'b10, player_win_light, dealer_win_light});
    done_q = done;
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge slow_clock); #1;
      check("reset_outputs_zero",
            {23'd0, load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
             load_dcard3, player_win_light, dealer_win_light, done}, 32'd0);
    end
  endtask

  task automatic start_hand(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3);
    apply_reset();
    pscore_in = p;
    dscore_in = d;
    pcard3_in = c3;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    exp_q.push_back(4'd3);
    exp_q.push_back(4'd4);
    reset = 1'b0;
    @(posedge slow_clock); #1;
    check("first_load_latency", {31'd0, load_pcard1}, 32'd1);
  endtask

  // chg: change to final scores pf/df once load_dcard3 is seen.
  task automatic run_hand(input logic [3:0] p, input logic [3:0] d, input logic [3:0] c3,
                          input logic chg, input logic [3:0] pf, input logic [3:0] df,
                          input logic exp_p3, input logic exp_d3, input logic [1:0] lights);
    bit seen;
    start_hand(p, d, c3);
    if (exp_p3) exp_q.push_back(4'd5);
    if (exp_d3) exp_q.push_back(4'd6);
    exp_q.push_back({2'b10, lights});
    if (chg) begin
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (load_dcard3) seen = 1;
        else begin @(posedge slow_clock); #1; end
      end
      check("wait_load_dcard3", {31'd0, seen}, 32'd1);
      pscore_in = pf;
      dscore_in = df;
    end
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done) seen = 1;
      else begin @(posedge slow_clock); #1; end
    end
    check("wait_done", {31'd0, seen}, 32'd1);
    repeat (3) begin
      @(posedge slow_clock); #1;
      check("done_held", {31'd0, done}, 32'd1);
    end
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    // natural: player 8 vs 3
    run_hand(4'd8, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10);
    // player draws, dealer 5 draws on 6; final 0 vs 1
    run_hand(4'd4, 4'd5, 4'd6, 1'b1, 4'd0, 4'd1, 1'b1, 1'b1, 2'b01);
    // dealer 3 stands on an 8
    run_hand(4'd3, 4'd3, 4'd8, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b11);
    // dealer 3 draws on a queen (value 0)
    run_hand(4'd3, 4'd3, 4'd12, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b11);
    // player stands on 7, dealer 5 draws; final 7 vs 7
    run_hand(4'd7, 4'd5, 4'd0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1, 2'b11);
    // both stand on 6
    run_hand(4'd6, 4'd6, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11);
    // dealer 7 never draws
    run_hand(4'd5, 4'd7, 4'd3, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b01);
    // dealer 4: draws on 2, stands on ace
    run_hand(4'd1, 4'd4, 4'd2, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b01);
    run_hand(4'd1, 4'd4, 4'd1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b01);
    // dealer 6: draws on 7, stands on 5
    run_hand(4'd0, 4'd6, 4'd7, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b01);
    run_hand(4'd0, 4'd6, 4'd5, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 2'b01);
    // dealer 2 always draws, even on an 8
    run_hand(4'd5, 4'd2, 4'd8, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 2'b10);
    // dealer natural 9 vs 2; tied naturals
    run_hand(4'd2, 4'd9, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b01);
    run_hand(4'd9, 4'd9, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b11);

    // reset during the load_pcard3 cycle
    begin
      bit seen;
      start_hand(4'd2, 4'd6, 4'd7);
      exp_q.push_back(4'd5);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        if (load_pcard3) seen = 1;
        else begin @(posedge slow_clock); #1; end
      end
      check("wait_load_pcard3", {31'd0, seen}, 32'd1);
      reset = 1'b1;
      @(posedge slow_clock); #1;
      check("abort_outputs_zero",
            {23'd0, load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2,
             load_dcard3, player_win_light, dealer_win_light, done}, 32'd0);
      @(negedge slow_clock);
      check("abort_queue_drained", exp_q.size(), 32'd0);
      exp_q.delete();
    end
    // restart after the aborted hand
    run_hand(4'd8, 4'd3, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
